// File: rtl/pwm_fade_pkg.sv
// pwm_fade_pkg: shared types and default widths for the PWM fade sequencer.
//   fade_state_t : sequencer state, 2-bit encoding (IDLE=0, RAMP_UP=1,
//                  HOLD=2, RAMP_DOWN=3), also exported on state_o.
//   *_DEF        : default widths for duty, prescaler and hold counter.
package pwm_fade_pkg;

  localparam int DUTY_W_DEF  = 8;
  localparam int PRESC_W_DEF = 16;
  localparam int HOLD_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } fade_state_t;

endpackage

// File: rtl/pwm_fade_sequencer_prescaler.sv
// fade_tick_prescaler: free-running tick generator for the fade sequencer.
//   clk, rst     : clock, synchronous active-high reset
//   clear        : synchronous counter clear (sequence start / abort)
//   en           : count enable (sequencer not idle)
//   period       : tick period minus 1, in clk cycles
//   tick         : high in the cycle where the counter equals period
module fade_tick_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               en,
  input  logic [PRESC_W-1:0] period,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt;

  // Combinational so the sequencer acts on the tick edge itself.
  assign tick = en && (cnt == period);

  always_ff @(posedge clk) begin
    if (rst || clear)
      cnt <= '0;
    else if (en)
      cnt <= tick ? '0 : cnt + PRESC_W'(1);
  end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// pwm_fade_sequencer: ramps PWM duty 0 -> target, holds, ramps back to 0,
// once or looping, stepping once per prescaler tick.
//   clk, rst      : clock, synchronous active-high reset
//   start, abort  : one-cycle pulses; abort wins over start and tick
//   cfg_target    : peak duty           cfg_step     : duty delta per tick
//   cfg_prescale  : tick period - 1     cfg_hold     : ticks at peak - 1
//   cfg_loop      : repeat until abort
//   duty_out      : sequenced duty      owns_duty    : high when not IDLE
//   done          : end-of-sequence pulse (non-loop only)
//   state_o       : current state encoding
// Optional build macro PWM_FADE_GAMMA_EN: duty_out = (d*d) >> DUTY_W with one
// registered stage; done, state_o and owns_duty are delayed to match.
module pwm_fade_sequencer
  import pwm_fade_pkg::*;
#(
  parameter int DUTY_W  = DUTY_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF,
  parameter int HOLD_W  = HOLD_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [DUTY_W-1:0]  cfg_target,
  input  logic [DUTY_W-1:0]  cfg_step,
  input  logic [PRESC_W-1:0] cfg_prescale,
  input  logic [HOLD_W-1:0]  cfg_hold,
  input  logic               cfg_loop,
  output logic [DUTY_W-1:0]  duty_out,
  output logic               owns_duty,
  output logic               done,
  output logic [1:0]         state_o
);

  fade_state_t        state;
  logic [DUTY_W-1:0]  duty_lin;
  logic               done_r;
  logic [HOLD_W-1:0]  hold_cnt;

  // Shadow config, captured only on an accepted start.
  logic [DUTY_W-1:0]  sh_target;
  logic [DUTY_W-1:0]  sh_step;
  logic [PRESC_W-1:0] sh_prescale;
  logic [HOLD_W-1:0]  sh_hold;
  logic               sh_loop;

  logic               tick;
  logic               start_ok;
  logic [DUTY_W-1:0]  eff_step;
  logic [DUTY_W:0]    sum;

  assign start_ok = start && (state == IDLE);
  // step=0 would stall the ramp forever; treat it as 1.
  assign eff_step = (sh_step == '0) ? DUTY_W'(1) : sh_step;
  // One extra bit so the up-ramp compare cannot wrap past target.
  assign sum      = {1'b0, duty_lin} + {1'b0, eff_step};

  fade_tick_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk    (clk),
    .rst    (rst),
    .clear  (abort || start_ok),
    .en     (state != IDLE),
    .period (sh_prescale),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      duty_lin    <= '0;
      done_r      <= 1'b0;
      hold_cnt    <= '0;
      sh_target   <= '0;
      sh_step     <= '0;
      sh_prescale <= '0;
      sh_hold     <= '0;
      sh_loop     <= 1'b0;
    end else if (abort) begin
      state    <= IDLE;
      duty_lin <= '0;
      done_r   <= 1'b0;
      hold_cnt <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sh_target   <= cfg_target;
            sh_step     <= cfg_step;
            sh_prescale <= cfg_prescale;
            sh_hold     <= cfg_hold;
            sh_loop     <= cfg_loop;
            duty_lin    <= '0;
            state       <= RAMP_UP;
          end
        end
        RAMP_UP: begin
          if (tick) begin
            if (sum >= {1'b0, sh_target}) begin
              duty_lin <= sh_target;
              hold_cnt <= '0;
              state    <= HOLD;
            end else begin
              duty_lin <= sum[DUTY_W-1:0];
            end
          end
        end
        HOLD: begin
          if (tick) begin
            if (hold_cnt == sh_hold) state <= RAMP_DOWN;
            else                     hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        RAMP_DOWN: begin
          if (tick) begin
            if (duty_lin <= eff_step) begin
              duty_lin <= '0;
              if (sh_loop) begin
                state <= RAMP_UP;
              end else begin
                state  <= IDLE;
                done_r <= 1'b1;
              end
            end else begin
              duty_lin <= duty_lin - eff_step;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PWM_FADE_GAMMA_EN
  logic [2*DUTY_W-1:0] sq;
  logic [DUTY_W-1:0]   duty_g;
  logic                done_d;
  logic [1:0]          state_d;

  assign sq = {{DUTY_W{1'b0}}, duty_lin} * {{DUTY_W{1'b0}}, duty_lin};

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_g  <= '0;
      done_d  <= 1'b0;
      state_d <= 2'd0;
    end else begin
      duty_g  <= sq[2*DUTY_W-1:DUTY_W];
      done_d  <= done_r;
      state_d <= state;
    end
  end

  assign duty_out  = duty_g;
  assign done      = done_d;
  assign state_o   = state_d;
  assign owns_duty = (state_d != 2'd0);
`else
  assign duty_out  = duty_lin;
  assign done      = done_r;
  assign state_o   = state;
  assign owns_duty = (state != IDLE);
`endif

endmodule
